// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the legality check on funct3.
package lsu_pkg;

  localparam int unsigned WordWidth = 32;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

  typedef enum logic [2:0] {StIdle, StRead, StWrite, StResp, StError} lsu_state_e;

  function automatic logic illegal_funct3(input logic write, input logic [2:0] f3);
    if (write) begin
      return !(f3 == F3Sb || f3 == F3Sh || f3 == F3Sw);
    end
    return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Lane selection for loads and stores: extends the addressed load lane, merges
// store bytes into the containing word and flags misaligned accesses.
module load_store_align
  import lsu_pkg::*;
(
  input  logic [2:0]           funct3,
  input  logic [1:0]           lane,
  input  logic [WordWidth-1:0] raw_word,
  input  logic [WordWidth-1:0] store_data,
  output logic [WordWidth-1:0] load_value,
  output logic [WordWidth-1:0] store_word,
  output logic                 misaligned
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = raw_word[{lane, 3'b000} +: 8];
    half_val = lane[1] ? raw_word[31:16] : raw_word[15:0];

    load_value = '0;
    case (funct3)
      F3Lb:    load_value = {{24{byte_val[7]}}, byte_val};
      F3Lh:    load_value = {{16{half_val[15]}}, half_val};
      F3Lw:    load_value = raw_word;
      F3Lbu:   load_value = {24'h000000, byte_val};
      F3Lhu:   load_value = {16'h0000, half_val};
      default: load_value = '0;
    endcase

    // funct3[1:0] encodes the access size for both loads and stores
    store_word = raw_word;
    case (funct3[1:0])
      2'b00:   store_word[{lane, 3'b000} +: 8] = store_data[7:0];
      2'b01:   store_word[{lane[1], 4'b0000} +: 16] = store_data[15:0];
      2'b10:   store_word = store_data;
      default: store_word = raw_word;
    endcase

    misaligned = (funct3[1:0] == 2'b01 && lane[0]) ||
                 (funct3[1:0] == 2'b10 && lane != 2'b00);
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: turns byte-addressed RV32I loads/stores into word
// accesses, with read-modify-write for SB/SH.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] byte_addr,
  input  logic [WordWidth-1:0]  store_data,
  output logic                  resp_valid,
  output logic [WordWidth-1:0]  load_data,
  output logic                  access_error,
  output logic                  mem_read_enable,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [WordWidth-1:0]  mem_write_data,
  input  logic [WordWidth-1:0]  mem_read_data
);

  lsu_state_e           state_q;
  logic                 write_q;
  logic [2:0]           funct3_q;
  logic [1:0]           lane_q;
  logic [WordWidth-1:0] store_data_q;

  logic                  idle;
  logic [2:0]            align_funct3;
  logic [1:0]            align_lane;
  logic [ADDR_WIDTH-1:0] word_index;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  req_error;
  logic [WordWidth-1:0]  load_value;
  logic [WordWidth-1:0]  store_word;

  // In IDLE the aligner checks the incoming request; afterwards it works on
  // the latched request and the word returned by memory.
  always_comb begin
    idle         = (state_q == StIdle);
    align_funct3 = idle ? funct3 : funct3_q;
    align_lane   = idle ? byte_addr[1:0] : lane_q;
    word_index   = {2'b00, byte_addr[ADDR_WIDTH-1:2]};
    out_of_range = word_index >= ADDR_WIDTH'(DEPTH_WORDS);
    req_error    = misaligned | out_of_range | illegal_funct3(req_write, funct3);
  end

  load_store_align u_align (
    .funct3     (align_funct3),
    .lane       (align_lane),
    .raw_word   (mem_read_data),
    .store_data (store_data_q),
    .load_value (load_value),
    .store_word (store_word),
    .misaligned (misaligned)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      write_q          <= 1'b0;
      funct3_q         <= '0;
      lane_q           <= '0;
      store_data_q     <= '0;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      access_error     <= 1'b0;
      load_data        <= '0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
    end else begin
      resp_valid       <= 1'b0;
      access_error     <= 1'b0;
      load_data        <= '0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            write_q      <= req_write;
            funct3_q     <= funct3;
            lane_q       <= byte_addr[1:0];
            store_data_q <= store_data;
            req_ready    <= 1'b0;
            if (req_error) begin
              state_q      <= StError;
              resp_valid   <= 1'b1;
              access_error <= 1'b1;
            end else begin
              mem_address <= word_index;
              if (req_write && funct3 == F3Sw) begin
                state_q          <= StWrite;
                mem_write_enable <= 1'b1;
                mem_write_data   <= store_data;
              end else begin
                state_q         <= StRead;
                mem_read_enable <= 1'b1;
              end
            end
          end
        end
        StRead: begin
          if (write_q) begin
            state_q          <= StWrite;
            mem_write_enable <= 1'b1;
            mem_write_data   <= store_word;
          end else begin
            state_q    <= StResp;
            resp_valid <= 1'b1;
            load_data  <= load_value;
          end
        end
        StWrite: begin
          state_q    <= StResp;
          resp_valid <= 1'b1;
        end
        default: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] byte_addr = '0;
  logic [31:0] store_data = '0;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        access_error;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  load_store_unit #(
    .DEPTH_WORDS (1024),
    .ADDR_WIDTH  (32)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .funct3           (funct3),
    .byte_addr        (byte_addr),
    .store_data       (store_data),
    .resp_valid       (resp_valid),
    .load_data        (load_data),
    .access_error     (access_error),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  always #5 clock = ~clock;

  // Word memory model; reset restores the preload image.
  logic [31:0] tb_mem [16];
  assign mem_read_data = tb_mem[mem_address[3:0]];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= (i == 1) ? 32'h80F17F02 : 32'h0;
    end else if (mem_write_enable) begin
      tb_mem[mem_address[3:0]] <= mem_write_data;
    end
  end

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } resp_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  resp_exp_t resp_q[$];
  wr_exp_t   wr_q[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int reads_seen = 0;
  int writes_seen = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a response or a write.
  always @(posedge clock) begin
    #1;
    if (mem_read_enable || mem_write_enable)
      check("enables_exclusive", 32'(mem_read_enable & mem_write_enable), 32'd0);
    if (mem_read_enable) reads_seen++;
    if (mem_write_enable) begin
      writes_seen++;
      if (wr_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_exp_t w;
        w = wr_q.pop_front();
        check("write_addr", mem_address, w.addr);
        check("write_data", mem_write_data, w.data);
      end
    end
    if (resp_valid) begin
      if (resp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        resp_exp_t e;
        e = resp_q.pop_front();
        check({e.name, "_data"}, load_data, e.data);
        check({e.name, "_err"}, 32'(access_error), 32'(e.err));
        check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic issue(input string name, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] exp_data, input logic exp_err, input int lat,
                       input logic has_wr, input logic [31:0] wr_addr,
                       input logic [31:0] wr_data);
    resp_exp_t e;
    wr_exp_t   w;
    int        waited;
    @(negedge clock);
    e.name = name;
    e.data = exp_data;
    e.err  = exp_err;
    e.cyc  = cyc + lat;
    resp_q.push_back(e);
    if (has_wr) begin
      w.addr = wr_addr;
      w.data = wr_data;
      wr_q.push_back(w);
    end
    req_valid  = 1'b1;
    req_write  = wr;
    funct3     = f3;
    byte_addr  = addr;
    store_data = sdata;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    check({name, "_ready_low"}, 32'(req_ready), 32'd0);
    waited = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0 || !req_ready) && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 20) begin
      check({name, "_timeout"}, 32'd1, 32'd0);
      resp_q.delete();
      wr_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_access_error", 32'(access_error), 32'd0);
    check("rst_rd_en", 32'(mem_read_enable), 32'd0);
    check("rst_wr_en", 32'(mem_write_enable), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_write_data", mem_write_data, 32'd0);
    reset = 1'b0;

    // name, wr, f3, addr, sdata, exp_data, exp_err, lat, has_wr, wr_addr, wr_data
    issue("lb4",   1'b0, 3'b000, 32'd4, 32'h0, 32'h00000002, 1'b0, 2, 1'b0, 0, 0);
    issue("lb7",   1'b0, 3'b000, 32'd7, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b0, 0, 0);
    issue("lbu7",  1'b0, 3'b100, 32'd7, 32'h0, 32'h00000080, 1'b0, 2, 1'b0, 0, 0);
    issue("lh6",   1'b0, 3'b001, 32'd6, 32'h0, 32'hFFFF80F1, 1'b0, 2, 1'b0, 0, 0);
    issue("lhu6",  1'b0, 3'b101, 32'd6, 32'h0, 32'h000080F1, 1'b0, 2, 1'b0, 0, 0);
    issue("lw4",   1'b0, 3'b010, 32'd4, 32'h0, 32'h80F17F02, 1'b0, 2, 1'b0, 0, 0);
    issue("sb5",   1'b1, 3'b000, 32'd5, 32'h000000AA, 32'h0, 1'b0, 3,
          1'b1, 32'd1, 32'h80F1AA02);
    issue("lb5",   1'b0, 3'b000, 32'd5, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 1'b0, 0, 0);
    issue("sw8",   1'b1, 3'b010, 32'd8, 32'hDEADBEEF, 32'h0, 1'b0, 2,
          1'b1, 32'd2, 32'hDEADBEEF);
    issue("lw8",   1'b0, 3'b010, 32'd8, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0, 0, 0);
    issue("lw6",   1'b0, 3'b010, 32'd6, 32'h0, 32'h0, 1'b1, 1, 1'b0, 0, 0);
    issue("sh3",   1'b1, 3'b001, 32'd3, 32'h1234, 32'h0, 1'b1, 1, 1'b0, 0, 0);
    issue("lb_oor", 1'b0, 3'b000, 32'h1000, 32'h0, 32'h0, 1'b1, 1, 1'b0, 0, 0);
    issue("ld_f3_011", 1'b0, 3'b011, 32'd0, 32'h0, 32'h0, 1'b1, 1, 1'b0, 0, 0);

    // Reset during the READ cycle of SB @5: no write, no response.
    @(negedge clock);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    funct3     = 3'b000;
    byte_addr  = 32'd5;
    store_data = 32'h55;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    check("mid_rst_in_read", 32'(mem_read_enable), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_rd_drop", 32'(mem_read_enable), 32'd0);
    check("mid_rst_wr_en", 32'(mem_write_enable), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("total_reads", 32'(reads_seen), 32'd10);
    check("total_writes", 32'(writes_seen), 32'd2);
    check("pending_resps", 32'(resp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface; sits between the execute stage and the word-organised data memory.
- Accepts byte-addressed RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Converts the byte address to a word index and drives the memory's read/write enables.
- Loads: extracts and sign/zero-extends the selected bytes. Sub-word stores: performs a read-modify-write of the containing word.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the data memory; byte addresses at or above 4*DEPTH_WORDS are out of range.
- ADDR_WIDTH, 32, width of the byte address and of mem_address.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present; sampled only when req_ready=1.
- req_ready  output  1  high only in IDLE.
- req_write  input  1  1=store, 0=load.
- funct3  input  3  RV32I width/sign code.
- byte_addr  input  ADDR_WIDTH  byte address.
- store_data  input  32  store operand; low bits used for SB/SH.
- resp_valid  output  1  one-cycle completion pulse.
- load_data  output  32  extended load result; valid with resp_valid.
- access_error  output  1  misaligned, out-of-range or illegal funct3; valid with resp_valid.
- mem_read_enable  output  1  to data memory.
- mem_write_enable  output  1  to data memory.
- mem_address  output  ADDR_WIDTH  word index (byte_addr >> 2).
- mem_write_data  output  32  word to write.
- mem_read_data  input  32  combinational read word from memory.

Behaviour:
- Reset: state=IDLE; req_ready=1; resp_valid, access_error, mem_read_enable and mem_write_enable=0; load_data, mem_address and mem_write_data=0.
- Request latch: in IDLE, req_valid=1 latches req_write, funct3, byte_addr and store_data, then moves to a new state.
  - Check: error (misaligned, out-of-range or illegal funct3) → ERROR.
  - Load → READ.
  - SW → WRITE.
  - SB/SH → READ.
- Misaligned rules: LH/LHU/SH with byte_addr[0]=1; LW/SW with byte_addr[1:0]≠0.
- Illegal funct3: loads 011/110/111; stores any value other than 000/001/010.
- READ (1 cycle): mem_read_enable=1, mem_address=byte_addr[ADDR_WIDTH-1:2]. mem_read_data is captured at the clock edge.
  - Load → RESP.
  - Sub-word store → WRITE.
- Load extraction:
  - Byte lane = byte_addr[1:0]; half lane = byte_addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- WRITE (1 cycle): mem_write_enable=1, same mem_address, then → RESP.
  - SW: mem_write_data = store_data.
  - SB/SH: mem_write_data = captured word with the addressed lane replaced by store_data[7:0] or store_data[15:0].
- RESP (1 cycle): resp_valid=1, access_error=0, load_data = extracted value (0 for stores), then → IDLE.
- ERROR (1 cycle): resp_valid=1, access_error=1, load_data=0, no memory enable asserted, then → IDLE.
- Latency from the request edge to resp_valid: load = 2 cycles; SW = 2; SB/SH = 3; error = 1.
- Throughput: req_ready=0 outside IDLE; requests presented then are ignored, not queued. resp_valid has no backpressure.
- Enables: mem_read_enable and mem_write_enable are never high together. Both are 0 in IDLE, RESP and ERROR.
- Reset mid-operation: immediate return to IDLE, enables drop asynchronously, no partial write issued, no response.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
  - State encoding: IDLE, READ, WRITE, RESP, ERROR.
  - Word-width constant: 32.
- One combinational sub-module, load_store_align: given funct3, byte_addr[1:0], the raw word and store_data, produces the extended load value, the merged store word and the misaligned flag.

Test Plan:
- Preload word 1 = 0x80F17F02. LB @4 → load_data=0x00000002, resp_valid 2 cycles after accept; LB @7 → 0xFFFFFF80; LBU @7 → 0x00000080.
- Same preload: LH @6 → 0xFFFF80F1; LHU @6 → 0x000080F1; LW @4 → 0x80F17F02.
- SB @5 data 0x000000AA on word 1 = 0x80F17F02 → READ then WRITE with mem_address=1, mem_write_data=0x80F1AA02, resp 3 cycles after accept.
- SW @8 data 0xDEADBEEF → single WRITE cycle, mem_address=2, mem_write_data=0xDEADBEEF, mem_read_enable never high; subsequent LW @8 returns 0xDEADBEEF.
- LW @6, SH @3, LB @0x1000 (DEPTH 1024), funct3=011 load → each gives access_error=1 and load_data=0 one cycle after accept, both enables stay 0.
- Assert reset during the READ cycle of SB @5 → mem_write_enable never asserted, no resp_valid, req_ready=1 after reset release.
